// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: FSM state encodings and
// default millisecond constants also used by the stopwatch control FSM.
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    BE_IDLE    = 3'd0,
    BE_PRESSED = 3'd1,
    BE_HELD    = 3'd2,
    BE_WAIT2   = 3'd3,
    BE_PRESS2  = 3'd4
  } be_state_e;

  localparam int unsigned BE_LONG_MS_DEF   = 1000;
  localparam int unsigned BE_REPEAT_MS_DEF = 200;
  localparam int unsigned BE_DOUBLE_MS_DEF = 250;
  localparam int unsigned BE_CNT_W_DEF     = 16;

endpackage

// File: rtl/button_event_decoder_if.sv
// Button-side bundle: timebase and debounced level in, event pulses and status out.
interface button_event_decoder_if;
  import button_event_decoder_pkg::*;

  logic clk_1ms;
  logic btn_level;
  logic short_press;
  logic double_click;
  logic long_press;
  logic repeat_pulse;
  logic held;
  logic busy;

  modport master (
    output clk_1ms, btn_level,
    input  short_press, double_click, long_press, repeat_pulse, held, busy
  );

  modport slave (
    input  clk_1ms, btn_level,
    output short_press, double_click, long_press, repeat_pulse, held, busy
  );

endinterface

// File: rtl/button_event_decoder_ms_tick_strobe.sv
// Rising-edge detector turning the slow 1 ms square wave into a 1-clk tick strobe.
module ms_tick_strobe (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic strobe
);

  logic level_prev_q;
  logic level_prev_d;

  always_comb level_prev_d = level_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_prev_q <= 1'b0;
    else     level_prev_q <= level_prev_d;
  end

  assign strobe = level_in & ~level_prev_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into short/double/long/repeat event pulses
// using a millisecond counter driven by the 1 ms timebase.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_MS   = BE_LONG_MS_DEF,
  parameter int unsigned REPEAT_MS = BE_REPEAT_MS_DEF,
  parameter int unsigned DOUBLE_MS = BE_DOUBLE_MS_DEF,
  parameter int unsigned CNT_W     = BE_CNT_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  button_event_decoder_if.slave bus
);

  localparam logic [CNT_W:0] LONG_N   = (CNT_W+1)'(LONG_MS);
  localparam logic [CNT_W:0] REPEAT_N = (CNT_W+1)'(REPEAT_MS);
  localparam logic [CNT_W:0] DOUBLE_N = (CNT_W+1)'(DOUBLE_MS);

  logic             tick;
  logic             press;
  logic             rel;
  logic [CNT_W:0]   ms_next;
  logic             exp_long;
  logic             exp_rep;
  logic             exp_dbl;

  be_state_e        state_q, state_d;
  logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
  logic             btn_prev_q, btn_prev_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             busy_q, busy_d;

  ms_tick_strobe u_tick (
    .clk      (clk),
    .rst      (rst),
    .level_in (bus.clk_1ms),
    .strobe   (tick)
  );

  assign press    = bus.btn_level & ~btn_prev_q;
  assign rel      = ~bus.btn_level & btn_prev_q;
  assign ms_next  = {1'b0, ms_cnt_q} + (CNT_W+1)'(1);
  assign exp_long = tick && (ms_next == LONG_N);
  assign exp_rep  = tick && (ms_next == REPEAT_N);
  assign exp_dbl  = tick && (ms_next == DOUBLE_N);

  always_comb begin
    btn_prev_d = bus.btn_level;
    state_d    = state_q;
    ms_cnt_d   = (tick && !(&ms_cnt_q)) ? ms_cnt_q + CNT_W'(1) : ms_cnt_q;
    short_d    = 1'b0;
    double_d   = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    // Release is tested before expiry, and press before window expiry, so the
    // user's edge always wins a same-cycle race against the timer.
    case (state_q)
      BE_IDLE: begin
        if (press) state_d = BE_PRESSED;
      end
      BE_PRESSED: begin
        if (rel) begin
          if (DOUBLE_MS == 0) begin
            short_d = 1'b1;
            state_d = BE_IDLE;
          end else begin
            state_d = BE_WAIT2;
          end
        end else if (exp_long) begin
          long_d  = 1'b1;
          state_d = BE_HELD;
        end
      end
      BE_HELD: begin
        if (rel) begin
          state_d = BE_IDLE;
        end else if (REPEAT_MS != 0 && exp_rep) begin
          repeat_d = 1'b1;
          ms_cnt_d = '0;
        end
      end
      BE_WAIT2: begin
        if (press) begin
          double_d = 1'b1;
          state_d  = BE_PRESS2;
        end else if (exp_dbl) begin
          short_d = 1'b1;
          state_d = BE_IDLE;
        end
      end
      BE_PRESS2: begin
        if (rel) state_d = BE_IDLE;
      end
      default: state_d = BE_IDLE;
    endcase

    if (state_d != state_q) ms_cnt_d = '0;

    held_d = (state_d == BE_HELD);
    busy_d = (state_d != BE_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BE_IDLE;
      ms_cnt_q   <= '0;
      btn_prev_q <= 1'b0;
      short_q    <= 1'b0;
      double_q   <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ms_cnt_q   <= ms_cnt_d;
      btn_prev_q <= btn_prev_d;
      short_q    <= short_d;
      double_q   <= double_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      held_q     <= held_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.short_press  = short_q;
  assign bus.double_click = double_q;
  assign bus.long_press   = long_q;
  assign bus.repeat_pulse = repeat_q;
  assign bus.held         = held_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench: two decoder builds share random and directed button stimulus;
// an event-level reference model predicts pulses, a negedge monitor checks them.
module tb_button_event_decoder;
  import button_event_decoder_pkg::*;

  localparam int L  = 10;
  localparam int R0 = 4;
  localparam int D0 = 5;
  localparam int R1 = 0;
  localparam int D1 = 0;

  localparam int EV_SHORT = 1;
  localparam int EV_DBL   = 2;
  localparam int EV_LONG  = 3;
  localparam int EV_REP   = 4;

  typedef struct packed {
    bit first;   // button down, first press of a sequence
    bit lng;     // long press already reported for this hold
    bit wait2;   // released short press, waiting for a second press
    bit second;  // second press of a double click still down
    int cnt;
    int rep;
    int gap;
    bit pb;
    bit pc;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_event_decoder_if bus0 ();
  button_event_decoder_if bus1 ();

  button_event_decoder #(.LONG_MS(L), .REPEAT_MS(R0), .DOUBLE_MS(D0), .CNT_W(16)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  button_event_decoder #(.LONG_MS(L), .REPEAT_MS(R1), .DOUBLE_MS(D1), .CNT_W(16)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   q0[$];
  int   q1[$];
  mdl_t m0, m1;
  bit   nb0, nh0, nb1, nh1;
  bit   eb0, eh0, eb1, eh1;
  int   ph = 0;
  bit   rel_pending = 1'b0;

  always @(posedge clk) begin
    eb0 <= nb0; eh0 <= nh0;
    eb1 <= nb1; eh1 <= nh1;
  end

  task automatic model_step(input int lms, input int rms, input int dms,
                            input bit b, input bit c, inout mdl_t m, output int ev);
    bit tick, press, rel;
    tick  = c & ~m.pc;
    press = b & ~m.pb;
    rel   = ~b & m.pb;
    ev    = 0;
    if (m.first) begin
      if (rel) begin
        if (!m.lng) begin
          if (dms == 0) ev = EV_SHORT;
          else begin m.wait2 = 1'b1; m.gap = 0; end
        end
        m.first = 1'b0;
        m.lng   = 1'b0;
      end else if (tick) begin
        if (!m.lng) begin
          m.cnt++;
          if (m.cnt == lms) begin ev = EV_LONG; m.lng = 1'b1; m.rep = 0; end
        end else if (rms != 0) begin
          m.rep++;
          if (m.rep == rms) begin ev = EV_REP; m.rep = 0; end
        end
      end
    end else if (m.wait2) begin
      if (press) begin
        ev = EV_DBL; m.wait2 = 1'b0; m.second = 1'b1;
      end else if (tick) begin
        m.gap++;
        if (m.gap == dms) begin ev = EV_SHORT; m.wait2 = 1'b0; end
      end
    end else if (m.second) begin
      if (rel) m.second = 1'b0;
    end else if (press) begin
      m.first = 1'b1; m.cnt = 0; m.lng = 1'b0;
    end
    m.pb = b;
    m.pc = c;
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic check_dut(input int k, input logic sp, input logic dc, input logic lp,
                           input logic rp, input logic bz, input logic hd,
                           input bit eb, input bit eh);
    int ev, hi, e;
    hi = int'(sp) + int'(dc) + int'(lp) + int'(rp);
    ev = sp ? EV_SHORT : dc ? EV_DBL : lp ? EV_LONG : rp ? EV_REP : 0;
    while (qsize(k) > 0 && qfront(k) / 8 < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL missed_pulse dut%0d: got nothing at cyc %0d, required ev=%0d",
               k, qfront(k) / 8, qfront(k) % 8);
      qpop(k);
    end
    if (hi > 0) begin
      n_cmp++;
      if (hi > 1) begin
        n_bad++;
        $display("FAIL one_hot dut%0d: got %0d pulses at cyc %0d, required 1", k, hi, cyc);
      end
      n_cmp++;
      if (qsize(k) == 0) begin
        n_bad++;
        $display("FAIL spurious_pulse dut%0d: got ev=%0d at cyc %0d, required none", k, ev, cyc);
      end else begin
        e = qfront(k);
        qpop(k);
        if (e != cyc * 8 + ev) begin
          n_bad++;
          $display("FAIL pulse dut%0d: got ev=%0d at cyc %0d, required ev=%0d at cyc %0d",
                   k, ev, cyc, e % 8, e / 8);
        end
      end
    end
    n_cmp++;
    if (bz !== eb || hd !== eh) begin
      n_bad++;
      $display("FAIL levels dut%0d cyc %0d: got busy=%0b held=%0b, required busy=%0b held=%0b",
               k, cyc, bz, hd, eb, eh);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_dut(0, bus0.short_press, bus0.double_click, bus0.long_press, bus0.repeat_pulse,
                bus0.busy, bus0.held, eb0, eh0);
      check_dut(1, bus1.short_press, bus1.double_click, bus1.long_press, bus1.repeat_pulse,
                bus1.busy, bus1.held, eb1, eh1);
    end
  end

  task automatic check_zero(input string tag);
    logic [5:0] a0, a1;
    a0 = {bus0.short_press, bus0.double_click, bus0.long_press, bus0.repeat_pulse, bus0.held, bus0.busy};
    a1 = {bus1.short_press, bus1.double_click, bus1.long_press, bus1.repeat_pulse, bus1.held, bus1.busy};
    n_cmp++;
    if (a0 !== 6'b0 || a1 !== 6'b0) begin
      n_bad++;
      $display("FAIL %s: got outputs dut0=%b dut1=%b, required all 0", tag, a0, a1);
    end
  endtask

  task automatic step(input bit b);
    int ev;
    bit c;
    @(posedge clk);
    #1;
    if (rel_pending) begin rst = 1'b0; rel_pending = 1'b0; end
    ph = (ph + 1) % 20;
    c  = (ph >= 10);
    bus0.btn_level = b; bus0.clk_1ms = c;
    bus1.btn_level = b; bus1.clk_1ms = c;
    if (!rst) begin
      model_step(L, R0, D0, b, c, m0, ev);
      if (ev != 0) q0.push_back((cyc + 1) * 8 + ev);
      model_step(L, R1, D1, b, c, m1, ev);
      if (ev != 0) q1.push_back((cyc + 1) * 8 + ev);
      nb0 = m0.first | m0.wait2 | m0.second; nh0 = m0.first & m0.lng;
      nb1 = m1.first | m1.wait2 | m1.second; nh1 = m1.first & m1.lng;
    end
  endtask

  task automatic hold_ticks(input bit b, input int n);
    int seen = 0;
    while (seen < n) begin
      step(b);
      if (ph == 10) seen++;
    end
  endtask

  task automatic to_before_tick(input bit b);
    while (((ph + 1) % 20) != 10) step(b);
  endtask

  // Leaves the next step clear of a tick so a press starts a full tick count.
  task automatic align();
    to_before_tick(1'b0);
    step(1'b0);
  endtask

  task automatic do_reset(input bit b);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m0 = '0; m1 = '0;
    nb0 = 0; nh0 = 0; nb1 = 0; nh1 = 0;
    while (q0.size() > 0 && q0[q0.size()-1] / 8 >= cyc) void'(q0.pop_back());
    while (q1.size() > 0 && q1[q1.size()-1] / 8 >= cyc) void'(q1.pop_back());
    #1;
    check_zero("reset_mid");
    step(b);
    step(b);
    rel_pending = 1'b1;
  endtask

  initial begin
    bit b;
    int dur;
    bus0.btn_level = 1'b0; bus0.clk_1ms = 1'b0;
    bus1.btn_level = 1'b0; bus1.clk_1ms = 1'b0;
    m0 = '0; m1 = '0;
    #2;
    check_zero("reset_state");
    repeat (3) @(posedge clk);
    rel_pending = 1'b1;

    // short press
    align(); step(1'b1); hold_ticks(1'b1, 3); step(1'b0); hold_ticks(1'b0, 8);
    // double click
    align(); step(1'b1); hold_ticks(1'b1, 2); step(1'b0); hold_ticks(1'b0, 2);
    step(1'b1); hold_ticks(1'b1, 2); step(1'b0); hold_ticks(1'b0, 8);
    // long press with repeats
    align(); step(1'b1); hold_ticks(1'b1, 19); step(1'b0); hold_ticks(1'b0, 8);
    // release on the LONG tick, then second press on the last window tick
    align(); step(1'b1); hold_ticks(1'b1, 9); to_before_tick(1'b1); step(1'b0);
    hold_ticks(1'b0, 4); to_before_tick(1'b0); step(1'b1);
    hold_ticks(1'b1, 1); step(1'b0); hold_ticks(1'b0, 8);
    // release exactly on the LONG tick, no second press
    align(); step(1'b1); hold_ticks(1'b1, 9); to_before_tick(1'b1); step(1'b0);
    hold_ticks(1'b0, 8);
    // reset in PRESSED and in HELD
    align(); step(1'b1); hold_ticks(1'b1, 7); do_reset(1'b0); hold_ticks(1'b0, 8);
    align(); step(1'b1); hold_ticks(1'b1, 12); do_reset(1'b0); hold_ticks(1'b0, 8);
    // long hold and short tap
    align(); step(1'b1); hold_ticks(1'b1, 20); step(1'b0); hold_ticks(1'b0, 8);
    align(); step(1'b1); hold_ticks(1'b1, 1); step(1'b0); hold_ticks(1'b0, 8);

    b = 1'b0;
    for (int i = 0; i < 90; i++) begin
      b   = ~b;
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 320) : $urandom_range(1, 60);
      repeat (dur) step(b);
      if ($urandom_range(0, 24) == 0) begin
        do_reset(1'b0);
        b = 1'b0;
      end
    end

    hold_ticks(1'b0, 12);
    repeat (5) step(1'b0);
    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL drain dut0: got %0d pending events, required 0", q0.size());
    end
    n_cmp++;
    if (q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain dut1: got %0d pending events, required 0", q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
